enoc_route_unit: RTL and testbench
==================================

ENOC_ROUTE_UNIT -- requirements
Module: enoc_route_unit

Interface
REQ-001 SHALL have parameter X_NODES, default 4, number of node columns (>=2).
REQ-002 SHALL have parameter Y_NODES, default 4, number of node rows (>=2).
REQ-003 SHALL have parameters X_LOC, Y_LOC, default 0, this router's coordinates.
REQ-004 SHALL have parameter TORUS, default 0: 0 = mesh, 1 = torus with wrap links.
REQ-005 SHALL have parameter PORTS, default 5, number of independent input channels.
REQ-006 SHALL have parameter DATA_W, default 32, payload width carried alongside the route.
REQ-007 SHALL have clk  input  1  clock; reset_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have i_val  input  PORTS  per-port flit valid.
REQ-009 SHALL have i_x_dest  input  PORTS x XW  destination column; XW = max(1, clog2(X_NODES)).
REQ-010 SHALL have i_y_dest  input  PORTS x YW  destination row; YW = max(1, clog2(Y_NODES)).
REQ-011 SHALL have i_data  input  PORTS x DATA_W  payload.
REQ-012 SHALL have o_rdy  output  PORTS  per-port input ready.
REQ-013 SHALL have o_val  output  PORTS  per-port buffered-route valid.
REQ-014 SHALL have o_req  output  PORTS x 5  one-hot request, bit order [c,n,e,s,w].
REQ-015 SHALL have o_data  output  PORTS x DATA_W  payload of the head entry.
REQ-016 SHALL have i_rdy  input  PORTS  downstream (switch allocator) accepts head entry.
REQ-017 SHALL have o_err  output  PORTS  sticky out-of-range-destination flag.

Function
REQ-018 Each port SHALL hold an independent 2-entry FIFO storing {route, payload}; ports SHALL not interact.
REQ-019 Push SHALL occur on clk edge when i_val && o_rdy; pop SHALL occur when o_val && i_rdy.
REQ-020 o_rdy SHALL be registered and equal (count < 2) after each edge; o_val SHALL equal (count > 0).
REQ-021 A flit pushed at edge t SHALL present o_val=1 with its o_req/o_data from edge t to t+1 onward (latency 1).
REQ-022 Simultaneous push and pop SHALL leave count unchanged; FIFO order SHALL be preserved.
REQ-023 o_req/o_data SHALL remain stable while o_val && !i_rdy.
REQ-024 Route SHALL be computed at push time from the input destination and stored.
REQ-025 Mesh: X first; x_dest>X_LOC -> e, x_dest<X_LOC -> w; else y_dest>Y_LOC -> n, y_dest<Y_LOC -> s; else c.
REQ-026 Torus: dx = (x_dest - X_LOC) mod X_NODES; dx=0 -> resolve Y; 0<dx<=X_NODES/2 (integer) -> e; else w.
REQ-027 Torus Y: dy = (y_dest - Y_LOC) mod Y_NODES; 0<dy<=Y_NODES/2 -> n; else s; tie (dx or dy = half, even size) -> e/n.
REQ-028 Modulo arithmetic SHALL be computed with at least XW+1 / YW+1 bits, no truncation.
REQ-029 x_dest>=X_NODES or y_dest>=Y_NODES at push SHALL store route c and set o_err for that port until reset.
REQ-030 o_req SHALL be all-zero whenever o_val=0.

Reset
REQ-031 While reset_n=0 at a clk edge: count=0, o_val=0, o_rdy=0, o_req=0, o_err=0; o_data SHALL be zero.
REQ-032 First edge with reset_n=1 SHALL set o_rdy=1; reset mid-operation SHALL discard all buffered flits.

Configuration
REQ-033 Macro ENOC_ADAPTIVE_ROUTE_EN SHALL enable minimal-adaptive routing and add input i_congest  PORTS-independent  5  per-output [c,n,e,s,w] congestion.
REQ-034 With macro: if both X and Y are productive and the X direction is congested while the Y direction is not, route SHALL choose Y; otherwise REQ-025..027 apply.
REQ-035 Without macro: i_congest SHALL not exist; routing SHALL be dimension-ordered only.

Verification
REQ-036 Mesh 4x4, loc (1,2): push dest (3,2) -> next cycle o_val=1, o_req=00100; dest (1,0) -> 00010; dest (1,2) -> 10000.
REQ-037 Torus 4x4, loc (0,0): dest (3,0) -> 00001 (w); dest (2,0) tie -> 00100 (e); dest (0,3) -> 00010 (s).
REQ-038 i_rdy=0, push flits A,B,C back-to-back -> A,B accepted, o_rdy=0 from third cycle; raise i_rdy -> A then B popped in order, o_rdy returns 1.
REQ-039 X_NODES=3, push x_dest=3 -> o_req=10000, o_err=1 held until reset_n=0.
REQ-040 Adaptive build, mesh 4x4 loc (1,1), dest (3,3), i_congest=00100 -> 01000; i_congest=01100 -> 00100.
REQ-041 Two entries buffered, assert reset_n=0 one cycle -> o_val=0, o_err=0, o_rdy=0; next cycle o_rdy=1, no stale flit emerges.

Source files
------------

// File: rtl/enoc_route_unit_if.sv
// Per-port flit bus between the input stage and the route unit.
// Build option ENOC_ADAPTIVE_ROUTE_EN adds the i_congest vector.
interface enoc_route_unit_if #(
    parameter int PORTS   = 5,
    parameter int X_NODES = 4,
    parameter int Y_NODES = 4,
    parameter int DATA_W  = 32
);
    localparam int XW = (X_NODES > 1) ? $clog2(X_NODES) : 1;
    localparam int YW = (Y_NODES > 1) ? $clog2(Y_NODES) : 1;

    logic [PORTS-1:0]             i_val;
    logic [PORTS-1:0][XW-1:0]     i_x_dest;
    logic [PORTS-1:0][YW-1:0]     i_y_dest;
    logic [PORTS-1:0][DATA_W-1:0] i_data;
    logic [PORTS-1:0]             o_rdy;
    logic [PORTS-1:0]             o_val;
    logic [PORTS-1:0][4:0]        o_req;
    logic [PORTS-1:0][DATA_W-1:0] o_data;
    logic [PORTS-1:0]             i_rdy;
    logic [PORTS-1:0]             o_err;
`ifdef ENOC_ADAPTIVE_ROUTE_EN
    logic [4:0]                   i_congest;
`endif

    modport master (
        output i_val, i_x_dest, i_y_dest, i_data, i_rdy,
`ifdef ENOC_ADAPTIVE_ROUTE_EN
        output i_congest,
`endif
        input  o_rdy, o_val, o_req, o_data, o_err
    );

    modport slave (
        input  i_val, i_x_dest, i_y_dest, i_data, i_rdy,
`ifdef ENOC_ADAPTIVE_ROUTE_EN
        input  i_congest,
`endif
        output o_rdy, o_val, o_req, o_data, o_err
    );
endinterface

// File: rtl/enoc_route_unit.sv
// Per-port route computation with a 2-entry {route, payload} FIFO per input.
// Build option ENOC_ADAPTIVE_ROUTE_EN enables minimal-adaptive X/Y selection.
module enoc_route_unit #(
    parameter int X_NODES = 4,
    parameter int Y_NODES = 4,
    parameter int X_LOC   = 0,
    parameter int Y_LOC   = 0,
    parameter int TORUS   = 0,
    parameter int PORTS   = 5,
    parameter int DATA_W  = 32
) (
    input logic          clk,
    input logic          reset_n,
    enoc_route_unit_if.slave bus
);
    localparam int XW    = (X_NODES > 1) ? $clog2(X_NODES) : 1;
    localparam int YW    = (Y_NODES > 1) ? $clog2(Y_NODES) : 1;
    localparam int ENT_W = 5 + DATA_W;

    localparam logic [4:0] DIR_C = 5'b10000;
    localparam logic [4:0] DIR_N = 5'b01000;
    localparam logic [4:0] DIR_E = 5'b00100;
    localparam logic [4:0] DIR_S = 5'b00010;
    localparam logic [4:0] DIR_W = 5'b00001;

    // Two guard bits keep (dest + NODES - LOC) free of overflow and underflow.
    localparam logic [XW+1:0] XN = (XW+2)'(X_NODES);
    localparam logic [XW+1:0] XL = (XW+2)'(X_LOC);
    localparam logic [XW+1:0] XH = (XW+2)'(X_NODES / 2);
    localparam logic [YW+1:0] YN = (YW+2)'(Y_NODES);
    localparam logic [YW+1:0] YL = (YW+2)'(Y_LOC);
    localparam logic [YW+1:0] YH = (YW+2)'(Y_NODES / 2);

    function automatic logic [4:0] route_of(
        input logic [XW-1:0] xd,
        input logic [YW-1:0] yd
`ifdef ENOC_ADAPTIVE_ROUTE_EN
        , input logic [4:0]  cong
`endif
    );
        logic [4:0]    x_dir;
        logic [4:0]    y_dir;
        logic [4:0]    r;
        logic [XW+1:0] dx;
        logic [YW+1:0] dy;
        x_dir = '0;
        y_dir = '0;
        dx    = '0;
        dy    = '0;
        if (TORUS != 0) begin
            dx = ({2'b00, xd} + XN - XL) % XN;
            dy = ({2'b00, yd} + YN - YL) % YN;
            if (dx != '0) x_dir = (dx <= XH) ? DIR_E : DIR_W;
            if (dy != '0) y_dir = (dy <= YH) ? DIR_N : DIR_S;
        end else begin
            if ({2'b00, xd} > XL)      x_dir = DIR_E;
            else if ({2'b00, xd} < XL) x_dir = DIR_W;
            if ({2'b00, yd} > YL)      y_dir = DIR_N;
            else if ({2'b00, yd} < YL) y_dir = DIR_S;
        end
        r = (x_dir != '0) ? x_dir : ((y_dir != '0) ? y_dir : DIR_C);
`ifdef ENOC_ADAPTIVE_ROUTE_EN
        // Sidestep to Y only when both dimensions make progress and only X is congested.
        if ((x_dir != '0) && (y_dir != '0) && ((cong & x_dir) != '0) && ((cong & y_dir) == '0))
            r = y_dir;
`endif
        return r;
    endfunction

    logic [PORTS-1:0][1:0][ENT_W-1:0] mem_q, mem_d;
    logic [PORTS-1:0][1:0]            count_q, count_d;
    logic [PORTS-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [PORTS-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PORTS-1:0]                 rdy_q, rdy_d;
    logic [PORTS-1:0]                 err_q, err_d;

    logic [PORTS-1:0]                 push, pop, bad_dest;
    logic [PORTS-1:0][ENT_W-1:0]      entry_in;

    always_comb begin
        push     = '0;
        pop      = '0;
        bad_dest = '0;
        entry_in = '0;
        for (int p = 0; p < PORTS; p++) begin
            push[p]     = bus.i_val[p] & rdy_q[p];
            pop[p]      = (count_q[p] != 2'd0) & bus.i_rdy[p];
            bad_dest[p] = ({1'b0, bus.i_x_dest[p]} >= (XW+1)'(X_NODES)) |
                          ({1'b0, bus.i_y_dest[p]} >= (YW+1)'(Y_NODES));
`ifdef ENOC_ADAPTIVE_ROUTE_EN
            entry_in[p] = {bad_dest[p] ? DIR_C :
                           route_of(bus.i_x_dest[p], bus.i_y_dest[p], bus.i_congest),
                           bus.i_data[p]};
`else
            entry_in[p] = {bad_dest[p] ? DIR_C :
                           route_of(bus.i_x_dest[p], bus.i_y_dest[p]),
                           bus.i_data[p]};
`endif
        end
    end

    always_comb begin
        mem_d    = mem_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        err_d    = err_q;
        rdy_d    = rdy_q;
        for (int p = 0; p < PORTS; p++) begin
            if (push[p]) begin
                mem_d[p][wr_ptr_q[p]] = entry_in[p];
                wr_ptr_d[p]           = ~wr_ptr_q[p];
                if (bad_dest[p]) err_d[p] = 1'b1;
            end
            if (pop[p]) rd_ptr_d[p] = ~rd_ptr_q[p];
            if (push[p] && !pop[p])      count_d[p] = count_q[p] + 2'd1;
            else if (!push[p] && pop[p]) count_d[p] = count_q[p] - 2'd1;
            rdy_d[p] = (count_d[p] < 2'd2);
        end
    end

    // Storage needs no reset: everything leaving the block is gated by o_val.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rdy_q    <= '0;
            err_q    <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
        end
        mem_q <= mem_d;
    end

    always_comb begin
        bus.o_val  = '0;
        bus.o_req  = '0;
        bus.o_data = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (count_q[p] != 2'd0) begin
                bus.o_val[p]                   = 1'b1;
                {bus.o_req[p], bus.o_data[p]}  = mem_q[p][rd_ptr_q[p]];
            end
        end
    end

    assign bus.o_rdy = rdy_q;
    assign bus.o_err = err_q;
endmodule

// File: tb/tb_enoc_route_unit.sv
// Drives three router configurations (4x4 mesh, 4x4 torus, 3x3 torus) with directed
// and random traffic, comparing against a queue-based routing model.
module tb_enoc_route_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Configuration of each instance, mirrored for the reference model.
    int cfg_xn [3] = '{4, 4, 3};
    int cfg_yn [3] = '{4, 4, 3};
    int cfg_xl [3] = '{1, 0, 1};
    int cfg_yl [3] = '{2, 0, 1};
    int cfg_tor[3] = '{0, 1, 1};

    logic [1:0]            in_val [3];
    logic [1:0][1:0]       in_xd  [3];
    logic [1:0][1:0]       in_yd  [3];
    logic [1:0][15:0]      in_data[3];
    logic [1:0]            in_rdy [3];
    logic [4:0]            in_cong[3];

    logic [1:0]            out_val [3];
    logic [1:0]            out_rdy [3];
    logic [1:0]            out_err [3];
    logic [1:0][4:0]       out_req [3];
    logic [1:0][15:0]      out_data[3];

    enoc_route_unit_if #(.PORTS(2), .X_NODES(4), .Y_NODES(4), .DATA_W(16)) if0 ();
    enoc_route_unit_if #(.PORTS(2), .X_NODES(4), .Y_NODES(4), .DATA_W(16)) if1 ();
    enoc_route_unit_if #(.PORTS(2), .X_NODES(3), .Y_NODES(3), .DATA_W(16)) if2 ();

    enoc_route_unit #(.X_NODES(4), .Y_NODES(4), .X_LOC(1), .Y_LOC(2), .TORUS(0),
                      .PORTS(2), .DATA_W(16)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    enoc_route_unit #(.X_NODES(4), .Y_NODES(4), .X_LOC(0), .Y_LOC(0), .TORUS(1),
                      .PORTS(2), .DATA_W(16)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    enoc_route_unit #(.X_NODES(3), .Y_NODES(3), .X_LOC(1), .Y_LOC(1), .TORUS(1),
                      .PORTS(2), .DATA_W(16)) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

    assign if0.i_val = in_val[0];  assign if0.i_x_dest = in_xd[0];  assign if0.i_y_dest = in_yd[0];
    assign if0.i_data = in_data[0]; assign if0.i_rdy = in_rdy[0];
    assign if1.i_val = in_val[1];  assign if1.i_x_dest = in_xd[1];  assign if1.i_y_dest = in_yd[1];
    assign if1.i_data = in_data[1]; assign if1.i_rdy = in_rdy[1];
    assign if2.i_val = in_val[2];  assign if2.i_x_dest = in_xd[2];  assign if2.i_y_dest = in_yd[2];
    assign if2.i_data = in_data[2]; assign if2.i_rdy = in_rdy[2];
`ifdef ENOC_ADAPTIVE_ROUTE_EN
    assign if0.i_congest = in_cong[0];
    assign if1.i_congest = in_cong[1];
    assign if2.i_congest = in_cong[2];
`endif

    assign out_val[0] = if0.o_val; assign out_rdy[0] = if0.o_rdy; assign out_err[0] = if0.o_err;
    assign out_req[0] = if0.o_req; assign out_data[0] = if0.o_data;
    assign out_val[1] = if1.o_val; assign out_rdy[1] = if1.o_rdy; assign out_err[1] = if1.o_err;
    assign out_req[1] = if1.o_req; assign out_data[1] = if1.o_data;
    assign out_val[2] = if2.o_val; assign out_rdy[2] = if2.o_rdy; assign out_err[2] = if2.o_err;
    assign out_req[2] = if2.o_req; assign out_data[2] = if2.o_data;

    // Model state per (instance, port): queue of {route, data}, ready and sticky error.
    logic [20:0] mq[6][$];
    bit          m_rdy[6];
    bit          m_err[6];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hop counts decide the direction; torus picks the shorter way round, east/north on a tie.
    function automatic logic [4:0] refRoute(input int d, input int xd, input int yd);
        int xn, yn, xl, yl, hops;
        logic [4:0] xdir, ydir;
        xn = cfg_xn[d]; yn = cfg_yn[d]; xl = cfg_xl[d]; yl = cfg_yl[d];
        xdir = 5'b0;
        ydir = 5'b0;
        if (xd >= xn || yd >= yn) return 5'b10000;
        if (cfg_tor[d] != 0) begin
            hops = (xd - xl + xn) % xn;
            if (hops != 0) xdir = (hops <= xn - hops) ? 5'b00100 : 5'b00001;
            hops = (yd - yl + yn) % yn;
            if (hops != 0) ydir = (hops <= yn - hops) ? 5'b01000 : 5'b00010;
        end else begin
            if (xd > xl) xdir = 5'b00100; else if (xd < xl) xdir = 5'b00001;
            if (yd > yl) ydir = 5'b01000; else if (yd < yl) ydir = 5'b00010;
        end
`ifdef ENOC_ADAPTIVE_ROUTE_EN
        if (xdir != 0 && ydir != 0 && (in_cong[d] & xdir) != 0 && (in_cong[d] & ydir) == 0)
            return ydir;
`endif
        if (xdir != 0) return xdir;
        if (ydir != 0) return ydir;
        return 5'b10000;
    endfunction

    task automatic clearInputs();
        for (int d = 0; d < 3; d++) begin
            in_val[d] = '0; in_xd[d] = '0; in_yd[d] = '0;
            in_data[d] = '0; in_rdy[d] = '0; in_cong[d] = '0;
        end
    endtask

    task automatic applyStimulus(input int d, input int p, input bit v, input int xd,
                                 input int yd, input int data, input bit rdy);
        in_val[d][p]  = v;
        in_xd[d][p]   = 2'(xd);
        in_yd[d][p]   = 2'(yd);
        in_data[d][p] = 16'(data);
        in_rdy[d][p]  = rdy;
    endtask

    // Advance the model by the coming edge, clock it, then compare every output.
    task automatic stepCycle();
        for (int d = 0; d < 3; d++) begin
            for (int p = 0; p < 2; p++) begin
                int k;
                bit push, pop;
                k = d * 2 + p;
                if (!reset_n) begin
                    mq[k].delete();
                    m_rdy[k] = 1'b0;
                    m_err[k] = 1'b0;
                end else begin
                    push = in_val[d][p] && m_rdy[k];
                    pop  = (mq[k].size() != 0) && in_rdy[d][p];
                    if (pop) void'(mq[k].pop_front());
                    if (push) begin
                        if (int'(in_xd[d][p]) >= cfg_xn[d] || int'(in_yd[d][p]) >= cfg_yn[d])
                            m_err[k] = 1'b1;
                        mq[k].push_back({refRoute(d, int'(in_xd[d][p]), int'(in_yd[d][p])),
                                         in_data[d][p]});
                    end
                    m_rdy[k] = (mq[k].size() < 2);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            for (int p = 0; p < 2; p++) begin
                int k;
                logic [20:0] head;
                k = d * 2 + p;
                head = (mq[k].size() != 0) ? mq[k][0] : 21'd0;
                checkOutput($sformatf("d%0d.p%0d val", d, p), out_val[d][p], mq[k].size() != 0);
                checkOutput($sformatf("d%0d.p%0d rdy", d, p), out_rdy[d][p], m_rdy[k]);
                checkOutput($sformatf("d%0d.p%0d err", d, p), out_err[d][p], m_err[k]);
                checkOutput($sformatf("d%0d.p%0d req", d, p), out_req[d][p], head[20:16]);
                checkOutput($sformatf("d%0d.p%0d data", d, p), out_data[d][p], head[15:0]);
            end
        end
    endtask

    initial begin
        clearInputs();
        reset_n = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("reset rdy", out_rdy[0], 2'b00);
        checkOutput("reset val", out_val[1], 2'b00);
        checkOutput("reset data", out_data[0][0], 16'h0);
        reset_n = 1'b1;
        stepCycle();
        checkOutput("first rdy", out_rdy[2], 2'b11);

        // Mesh 4x4 at (1,2): east, south, local.
        applyStimulus(0, 0, 1, 3, 2, 16'h1111, 0); stepCycle();
        checkOutput("mesh east val", out_val[0][0], 1'b1);
        checkOutput("mesh east req", out_req[0][0], 5'b00100);
        applyStimulus(0, 0, 1, 1, 0, 16'h2222, 1); stepCycle();
        checkOutput("mesh south req", out_req[0][0], 5'b00010);
        checkOutput("mesh south data", out_data[0][0], 16'h2222);
        applyStimulus(0, 0, 1, 1, 2, 16'h3333, 1); stepCycle();
        checkOutput("mesh local req", out_req[0][0], 5'b10000);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); stepCycle();
        checkOutput("mesh drained req", out_req[0][0], 5'b00000);

        // Torus 4x4 at (0,0): wrap west, tie east, wrap south.
        applyStimulus(1, 1, 1, 3, 0, 16'hA001, 0); stepCycle();
        checkOutput("torus west req", out_req[1][1], 5'b00001);
        applyStimulus(1, 1, 1, 2, 0, 16'hA002, 1); stepCycle();
        checkOutput("torus tie req", out_req[1][1], 5'b00100);
        applyStimulus(1, 1, 1, 0, 3, 16'hA003, 1); stepCycle();
        checkOutput("torus south req", out_req[1][1], 5'b00010);
        applyStimulus(1, 1, 0, 0, 0, 0, 1); stepCycle();

        // Backpressure: A, B fill the FIFO, C is refused, then drain in order.
        applyStimulus(0, 1, 1, 2, 2, 16'h000A, 0); stepCycle();
        applyStimulus(0, 1, 1, 2, 2, 16'h000B, 0); stepCycle();
        checkOutput("full rdy", out_rdy[0][1], 1'b0);
        applyStimulus(0, 1, 1, 2, 2, 16'h000C, 0); stepCycle();
        checkOutput("held rdy", out_rdy[0][1], 1'b0);
        checkOutput("held data", out_data[0][1], 16'h000A);
        applyStimulus(0, 1, 0, 0, 0, 0, 1); stepCycle();
        checkOutput("pop A data", out_data[0][1], 16'h000B);
        checkOutput("pop A rdy", out_rdy[0][1], 1'b1);
        stepCycle();
        checkOutput("pop B val", out_val[0][1], 1'b0);

        // 3x3 instance: out-of-range column routes locally and sets a sticky error.
        applyStimulus(2, 0, 1, 3, 0, 16'hBAD0, 0); stepCycle();
        checkOutput("bad dest req", out_req[2][0], 5'b10000);
        checkOutput("bad dest err", out_err[2][0], 1'b1);
        applyStimulus(2, 0, 0, 0, 0, 0, 1); stepCycle(); stepCycle();
        checkOutput("err sticky", out_err[2][0], 1'b1);

`ifdef ENOC_ADAPTIVE_ROUTE_EN
        in_cong[0] = 5'b00100;
        applyStimulus(0, 0, 1, 3, 3, 16'hC001, 0); stepCycle();
        checkOutput("adaptive y req", out_req[0][0], 5'b01000);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); stepCycle();
        in_cong[0] = 5'b01100;
        applyStimulus(0, 0, 1, 3, 3, 16'hC002, 0); stepCycle();
        checkOutput("adaptive x req", out_req[0][0], 5'b00100);
        applyStimulus(0, 0, 0, 0, 0, 0, 1); stepCycle();
        in_cong[0] = 5'b00000;
`endif

        // Reset with two flits buffered discards them and clears the error.
        applyStimulus(0, 0, 1, 0, 0, 16'hD001, 0); stepCycle();
        applyStimulus(0, 0, 1, 3, 3, 16'hD002, 0); stepCycle();
        checkOutput("prefill rdy", out_rdy[0][0], 1'b0);
        clearInputs();
        reset_n = 1'b0; stepCycle();
        checkOutput("midreset val", out_val[0][0], 1'b0);
        checkOutput("midreset rdy", out_rdy[0][0], 1'b0);
        checkOutput("midreset err", out_err[2][0], 1'b0);
        reset_n = 1'b1;
        in_rdy[0] = 2'b11;
        stepCycle();
        checkOutput("post reset rdy", out_rdy[0][0], 1'b1);
        checkOutput("post reset val", out_val[0][0], 1'b0);

        // Random traffic on all instances with occasional resets.
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int d = 0; d < 3; d++) begin
                for (int p = 0; p < 2; p++) begin
                    applyStimulus(d, p, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                                  $urandom_range(0, 3), $urandom_range(0, 65535),
                                  $urandom_range(0, 9) < 6);
                end
                in_cong[d] = 5'($urandom_range(0, 31));
            end
            reset_n = ($urandom_range(0, 99) != 0);
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
